// File: rtl/spi_cmd_pkg.sv
// Shared encodings for the SPI command controller: opcodes, header layout,
// FSM states and error-flag bit positions.
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_WRITE  = 2'b01,
        OP_READ   = 2'b10,
        OP_STATUS = 2'b11
    } op_t;

    localparam int OP_LSB  = 30;
    localparam int OP_W    = 2;
    localparam int LEN_LSB = 24;
    localparam int LEN_W   = 6;
    localparam int RSV_LSB = 16;
    localparam int RSV_W   = 8;

    localparam int ERR_OVERRUN = 0;
    localparam int ERR_TIMEOUT = 1;
    localparam int ERR_OPCODE  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_BUS,
        ST_RD_BUS,
        ST_TX_WAIT
    } state_t;

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// Word handshakes to spi_slave, register-bus signals and status outputs.
interface spi_cmd_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              cs_n;
    logic [31:0]       rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [31:0]       tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_ack;
    logic              busy;
    logic [2:0]        err_flags;

    modport master (
        input  cs_n, rx_data, rx_valid, tx_ready, bus_rdata, bus_ack,
        output rx_ready, tx_data, tx_valid, bus_req, bus_we, bus_addr, bus_wdata,
               busy, err_flags
    );

    modport slave (
        output cs_n, rx_data, rx_valid, tx_ready, bus_rdata, bus_ack,
        input  rx_ready, tx_data, tx_valid, bus_req, bus_we, bus_addr, bus_wdata,
               busy, err_flags
    );
endinterface

// File: rtl/spi_cmd_timeout.sv
// Bus-ack watchdog: loaded when a request starts, expires after TIMEOUT
// cycles of the request being held.
module spi_cmd_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = TW'(TIMEOUT - 1);
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = en && !load && (cnt_q == '0);

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Decodes SPI command words into register-bus writes/reads and returns
// read data / status words to spi_slave.
//   state      | meaning
//   IDLE       | waiting for a header word
//   WR_DATA    | waiting for the next write data word
//   WR_BUS     | bus write in flight
//   RD_BUS     | bus read in flight
//   TX_WAIT    | tx word presented, waiting for spi_slave to take it
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input logic             clk,
    input logic             rst,
    spi_cmd_ctrl_if.master  io
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic [2:0]        err_q, err_d;
    logic              rx_ready_q, rx_ready_d;

    logic       busy;
    logic       accept;
    logic       tmo_expired;
    logic [2:0] err_set;
    logic       err_clr;

    assign busy   = (state_q != ST_IDLE);
    assign accept = io.rx_valid && rx_ready_q && !io.cs_n;

    spi_cmd_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .load    (bus_req_d && !bus_req_q),
        .en      (bus_req_q),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        bus_req_d  = bus_req_q;
        bus_we_d   = bus_we_q;
        wdata_d    = wdata_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        err_set    = '0;
        err_clr    = 1'b0;

        if (io.rx_valid && !rx_ready_q && !io.cs_n) err_set[ERR_OVERRUN] = 1'b1;

        if (io.cs_n) begin
            state_d    = ST_IDLE;
            bus_req_d  = 1'b0;
            tx_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (io.rx_data[RSV_LSB +: RSV_W] != '0) begin
                            err_set[ERR_OPCODE] = 1'b1;
                        end else begin
                            case (op_t'(io.rx_data[OP_LSB +: OP_W]))
                                OP_NOP: ;
                                OP_WRITE: begin
                                    addr_d  = io.rx_data[ADDR_W-1:0];
                                    cnt_d   = io.rx_data[LEN_LSB +: LEN_W];
                                    state_d = ST_WR_DATA;
                                end
                                OP_READ: begin
                                    addr_d    = io.rx_data[ADDR_W-1:0];
                                    cnt_d     = io.rx_data[LEN_LSB +: LEN_W];
                                    bus_req_d = 1'b1;
                                    bus_we_d  = 1'b0;
                                    state_d   = ST_RD_BUS;
                                end
                                OP_STATUS: begin
                                    tx_data_d  = {busy, 26'b0, err_q, 2'b0};
                                    tx_valid_d = 1'b1;
                                    err_clr    = 1'b1;
                                    cnt_d      = '0;
                                    state_d    = ST_TX_WAIT;
                                end
                            endcase
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (accept) begin
                        wdata_d   = io.rx_data;
                        bus_req_d = 1'b1;
                        bus_we_d  = 1'b1;
                        state_d   = ST_WR_BUS;
                    end
                end
                ST_WR_BUS: begin
                    // ack takes priority over a coincident timeout
                    if (io.bus_ack) begin
                        bus_req_d = 1'b0;
                        addr_d    = addr_q + ADDR_W'(1);
                        if (cnt_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d   = cnt_q - LEN_W'(1);
                            state_d = ST_WR_DATA;
                        end
                    end else if (tmo_expired) begin
                        bus_req_d            = 1'b0;
                        err_set[ERR_TIMEOUT] = 1'b1;
                        state_d              = ST_IDLE;
                    end
                end
                ST_RD_BUS: begin
                    if (io.bus_ack) begin
                        bus_req_d  = 1'b0;
                        tx_data_d  = io.bus_rdata;
                        tx_valid_d = 1'b1;
                        state_d    = ST_TX_WAIT;
                    end else if (tmo_expired) begin
                        bus_req_d            = 1'b0;
                        err_set[ERR_TIMEOUT] = 1'b1;
                        state_d              = ST_IDLE;
                    end
                end
                ST_TX_WAIT: begin
                    if (io.tx_ready) begin
                        tx_valid_d = 1'b0;
                        addr_d     = addr_q + ADDR_W'(1);
                        if (cnt_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d     = cnt_q - LEN_W'(1);
                            bus_req_d = 1'b1;
                            bus_we_d  = 1'b0;
                            state_d   = ST_RD_BUS;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // a flag raised in the same cycle as a STATUS clear survives
        err_d      = (err_clr ? 3'b000 : err_q) | err_set;
        rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_WR_DATA);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            bus_req_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            wdata_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            bus_req_q  <= bus_req_d;
            bus_we_q   <= bus_we_d;
            wdata_q    <= wdata_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    assign io.rx_ready  = rx_ready_q;
    assign io.tx_data   = tx_data_q;
    assign io.tx_valid  = tx_valid_q;
    assign io.bus_req   = bus_req_q;
    assign io.bus_we    = bus_we_q;
    assign io.bus_addr  = addr_q;
    assign io.bus_wdata = wdata_q;
    assign io.busy      = busy;
    assign io.err_flags = err_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: expected bus cycles and tx words are queued
// as commands are sent and checked when the controller produces them.
module tb_spi_cmd_ctrl;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;
    bit ack_en   = 1'b1;

    bus_exp_t    exp_bus[$];
    logic [31:0] exp_tx[$];
    logic [31:0] rdata_q[$];

    spi_cmd_ctrl_if #(.ADDR_W(16)) io ();

    spi_cmd_ctrl #(.ADDR_W(16), .TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_bus(input logic we, input logic [15:0] addr, input logic [31:0] wdata);
        bus_exp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata;
        exp_bus.push_back(e);
    endtask

    task automatic send(input logic [31:0] w);
        for (int i = 0; i < 100 && io.rx_ready !== 1'b1; i++) @(negedge clk);
        chk("rx_ready", io.rx_ready, 32'd1);
        io.rx_data  = w;
        io.rx_valid = 1'b1;
        @(negedge clk);
        io.rx_valid = 1'b0;
    endtask

    task automatic read_tx();
        logic [31:0] e;
        for (int i = 0; i < 100 && io.tx_valid !== 1'b1; i++) @(negedge clk);
        chk("tx_valid", io.tx_valid, 32'd1);
        e = exp_tx.pop_front();
        chk("tx_data", io.tx_data, e);
        repeat (2) @(negedge clk);
        chk("tx_hold_data", io.tx_data, e);
        chk("tx_hold_valid", io.tx_valid, 32'd1);
        io.tx_ready = 1'b1;
        @(negedge clk);
        io.tx_ready = 1'b0;
        chk("tx_drop", io.tx_valid, 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && io.busy !== 1'b0; i++) @(negedge clk);
        chk(tag, io.busy, 32'd0);
    endtask

    // Bus model: checks each new request against the scoreboard, checks that
    // address/direction/data stay put while it is held, and acks on cycle 2.
    initial begin : responder
        bus_exp_t    e;
        logic        req_prev = 1'b0;
        int          req_cyc  = 0;
        logic [15:0] cap_addr;
        logic        cap_we;
        logic [31:0] cap_wdata;
        io.bus_ack   = 1'b0;
        io.bus_rdata = '0;
        forever begin
            @(negedge clk);
            io.bus_ack = 1'b0;
            if (io.bus_req === 1'b1) begin
                if (!req_prev) begin
                    req_cyc   = 0;
                    cap_addr  = io.bus_addr;
                    cap_we    = io.bus_we;
                    cap_wdata = io.bus_wdata;
                    n_assert++;
                    assert (exp_bus.size() > 0)
                    else begin
                        n_fail++;
                        $error("FAIL bus_unexpected observed addr=%h expected no request", io.bus_addr);
                    end
                    if (exp_bus.size() > 0) begin
                        e = exp_bus.pop_front();
                        chk("bus_we", io.bus_we, e.we);
                        chk("bus_addr", io.bus_addr, e.addr);
                        if (e.we) chk("bus_wdata", io.bus_wdata, e.wdata);
                    end
                end else begin
                    chk("bus_addr_stable", io.bus_addr, cap_addr);
                    chk("bus_we_stable", io.bus_we, cap_we);
                    chk("bus_wdata_stable", io.bus_wdata, cap_wdata);
                end
                req_cyc++;
                if (ack_en && req_cyc == 2) begin
                    io.bus_ack   = 1'b1;
                    io.bus_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'hBAD0_BAD0;
                end
            end
            req_prev = io.bus_req;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        int  hi_cyc;
        bit  saw_tx;
        io.cs_n     = 1'b0;
        io.rx_data  = '0;
        io.rx_valid = 1'b0;
        io.tx_ready = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", io.rx_ready, 32'd0);
        chk("rst_tx_valid", io.tx_valid, 32'd0);
        chk("rst_tx_data", io.tx_data, 32'd0);
        chk("rst_bus_req", io.bus_req, 32'd0);
        chk("rst_bus_addr", io.bus_addr, 32'd0);
        chk("rst_busy", io.busy, 32'd0);
        chk("rst_err", io.err_flags, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single write
        push_bus(1'b1, 16'h0010, 32'hDEAD_BEEF);
        send(32'h4000_0010);
        chk("wr_busy", io.busy, 32'd1);
        send(32'hDEAD_BEEF);
        chk("wr_req_next_cycle", io.bus_req, 32'd1);
        wait_idle("wr_idle");

        // burst read LEN=2 at 0x20
        for (int i = 0; i < 3; i++) begin
            push_bus(1'b0, 16'h0020 + 16'(i), 32'h0);
            rdata_q.push_back(32'h11 * (i + 1));
            exp_tx.push_back(32'h11 * (i + 1));
        end
        send(32'h8200_0020);
        for (int i = 0; i < 3; i++) read_tx();
        wait_idle("rd_idle");

        // address wrap
        push_bus(1'b1, 16'hFFFF, 32'hA5A5_0001);
        push_bus(1'b1, 16'h0000, 32'hA5A5_0002);
        send(32'h4100_FFFF);
        send(32'hA5A5_0001);
        send(32'hA5A5_0002);
        wait_idle("wrap_idle");

        // timeout on read
        ack_en = 1'b0;
        push_bus(1'b0, 16'h0030, 32'h0);
        send(32'h8000_0030);
        for (int i = 0; i < 10 && io.bus_req !== 1'b1; i++) @(negedge clk);
        hi_cyc = 0;
        saw_tx = 1'b0;
        for (int i = 0; i < 400 && io.bus_req === 1'b1; i++) begin
            hi_cyc++;
            if (io.tx_valid === 1'b1) saw_tx = 1'b1;
            @(negedge clk);
        end
        ack_en = 1'b1;
        chk("tmo_req_cycles", hi_cyc, 32'd255);
        chk("tmo_no_tx", {31'b0, saw_tx | io.tx_valid}, 32'd0);
        chk("tmo_err", io.err_flags, 32'b010);
        chk("tmo_busy", io.busy, 32'd0);

        exp_tx.push_back(32'h0000_0008);
        send(32'hC000_0000);
        chk("status_clr_tmo", io.err_flags, 32'd0);
        read_tx();

        // overrun during WR_BUS, then STATUS
        push_bus(1'b1, 16'h0040, 32'h1234_5678);
        send(32'h4000_0040);
        send(32'h1234_5678);
        io.rx_data  = 32'hFFFF_FFFF;
        io.rx_valid = 1'b1;
        @(negedge clk);
        io.rx_valid = 1'b0;
        wait_idle("ovr_idle");
        chk("ovr_err", io.err_flags, 32'b001);
        exp_tx.push_back(32'h0000_0004);
        send(32'hC000_0000);
        chk("status_clr_ovr", io.err_flags, 32'd0);
        read_tx();

        // reserved bits set: header ignored, opcode flag
        send(32'h4001_0000);
        chk("opc_busy", io.busy, 32'd0);
        chk("opc_err", io.err_flags, 32'b100);
        exp_tx.push_back(32'h0000_0010);
        send(32'hC000_0000);
        read_tx();

        // cs_n abort mid burst write, then a late ack
        ack_en = 1'b0;
        push_bus(1'b1, 16'h0050, 32'hAAAA_0001);
        send(32'h4300_0050);
        send(32'hAAAA_0001);
        for (int i = 0; i < 10 && io.bus_req !== 1'b1; i++) @(negedge clk);
        chk("abort_req_before", io.bus_req, 32'd1);
        repeat (3) @(negedge clk);
        io.cs_n = 1'b1;
        @(negedge clk);
        io.cs_n = 1'b0;
        chk("abort_busy", io.busy, 32'd0);
        chk("abort_req", io.bus_req, 32'd0);
        #1 io.bus_ack = 1'b1;
        io.bus_rdata = 32'h5555_5555;
        @(negedge clk);
        io.bus_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_busy", io.busy, 32'd0);
        chk("late_ack_req", io.bus_req, 32'd0);
        chk("late_ack_tx", io.tx_valid, 32'd0);
        chk("late_ack_err", io.err_flags, 32'd0);
        ack_en = 1'b1;

        // recovery after abort
        push_bus(1'b1, 16'h0060, 32'hCAFE_F00D);
        send(32'h4000_0060);
        send(32'hCAFE_F00D);
        wait_idle("recover_idle");

        repeat (3) @(negedge clk);
        chk("bus_queue_empty", exp_bus.size(), 32'd0);
        chk("tx_queue_empty", exp_tx.size(), 32'd0);
        chk("final_err", io.err_flags, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
